seg_scan_drv: RTL and testbench

SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

---
 rtl/seg_scan_drv.sv | 119 +++++++++++
 tb/tb_seg_scan_drv.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_drv.sv
// seg_scan_drv: four-digit multiplexed 7-segment scanner.
// Shadow/display double buffer, publish at frame boundary.
module seg_scan_drv #(
  parameter int DIV  = 1000,
  parameter int DEAD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_idx,
  input  logic [7:0] wr_seg,
  input  logic       commit,
  input  logic       blank,
  output logic [3:0] an,
  output logic [7:0] seg,
  output logic       commit_ack,
  output logic       frame_tick
);

  logic [15:0] r_cnt;
  logic [1:0]  r_dig;
  logic        r_pend;
  logic [7:0]  r_shadow [4];
  logic [7:0]  r_disp   [4];
  logic [3:0]  r_an;
  logic [7:0]  r_seg;
  logic        r_ack;
  logic        r_tick;

  logic        w_wrap;
  logic        w_bound;
  logic        w_copy;
  logic        w_dead;
  logic [15:0] w_cnt_nx;
  logic [1:0]  w_dig_nx;
  logic [7:0]  w_seg_nx;

  assign w_wrap   = (r_cnt == 16'(DIV - 1));
  assign w_bound  = w_wrap && (r_dig == 2'd3);
  assign w_copy   = w_bound && (r_pend || commit);
  assign w_cnt_nx = w_wrap ? 16'd0 : r_cnt + 16'd1;
  assign w_dig_nx = w_wrap ? r_dig + 2'd1 : r_dig;

  // On a copy edge the next slot is digit 0 and must
  // already show the freshly published pattern.
  assign w_seg_nx = w_copy ? r_shadow[w_dig_nx]
                           : r_disp[w_dig_nx];

  generate
    if (DEAD == 0) begin : g_nodead
      assign w_dead = 1'b0;
    end else begin : g_dead
      assign w_dead = (w_cnt_nx < 16'(DEAD));
    end
  endgenerate

  // Prescaler, digit index and commit-pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt  <= 16'd0;
      r_dig  <= 2'd0;
      r_pend <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nx;
      r_dig <= w_dig_nx;
      if (w_bound)
        r_pend <= 1'b0;
      else if (commit)
        r_pend <= 1'b1;
    end
  end

  // Host-written shadow buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        r_shadow[i] <= 8'hFF;
    end else if (wr_en) begin
      r_shadow[wr_idx] <= wr_seg;
    end
  end

  // Display buffer, refreshed from pre-edge shadow at boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++)
        r_disp[i] <= 8'hFF;
    end else if (w_copy) begin
      for (int i = 0; i < 4; i++)
        r_disp[i] <= r_shadow[i];
    end
  end

  // Registered pin drive and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an   <= 4'hF;
      r_seg  <= 8'hFF;
      r_ack  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_ack  <= w_copy;
      r_tick <= w_bound;
      if (blank || w_dead) begin
        r_an  <= 4'hF;
        r_seg <= 8'hFF;
      end else begin
        r_an  <= ~(4'b0001 << w_dig_nx);
        r_seg <= w_seg_nx;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign commit_ack = r_ack;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_seg_scan_drv.sv
// tb_seg_scan_drv: directed checks of seg_scan_drv
// with DIV=4, DEAD=1 (16-cycle frame).
module tb_seg_scan_drv;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [1:0] wr_idx = 2'd0;
  logic [7:0] wr_seg = 8'h00;
  logic       commit = 1'b0;
  logic       blank = 1'b0;
  logic [3:0] an;
  logic [7:0] seg;
  logic       commit_ack;
  logic       frame_tick;

  seg_scan_drv #(.DIV(4), .DEAD(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_seg     (wr_seg),
    .commit     (commit),
    .blank      (blank),
    .an         (an),
    .seg        (seg),
    .commit_ack (commit_ack),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int ph = 0;
  int ack_a = -1;
  int ack_b = -1;
  int bl_lo = -1;
  int bl_hi = -2;
  logic [7:0] sh [4];
  logic [7:0] ed [4];

  task automatic step();
    @(posedge clk);
    #1;
    ph++;
  endtask

  function automatic logic blanked(int k);
    return (k >= bl_lo && k <= bl_hi) || (k % 4 == 0);
  endfunction

  function automatic logic [3:0] exp_an(int k);
    logic [3:0] one;
    one = 4'b0001;
    if (blanked(k)) return 4'hF;
    return ~(one << ((k / 4) % 4));
  endfunction

  function automatic logic [7:0] exp_seg(int k);
    if (blanked(k)) return 8'hFF;
    return ed[(k / 4) % 4];
  endfunction

  function automatic logic exp_ack(int k);
    return (k == ack_a) || (k == ack_b);
  endfunction

  function automatic logic exp_tick(int k);
    return (k > 0) && (k % 16 == 0);
  endfunction

  task automatic drive_idle();
    wr_en = 1'b0;
    commit = 1'b0;
  endtask

  task automatic drive_wr(input logic [1:0] i, input logic [7:0] v);
    wr_en = 1'b1;
    wr_idx = i;
    wr_seg = v;
  endtask

  // Advance one cycle and update the shadow/display model:
  // a copy sees the shadow as it was before this edge.
  task automatic adv();
    step();
    if (exp_ack(ph)) ed = sh;
    if (wr_en) sh[wr_idx] = wr_seg;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_wr(2'd0, 8'h55);
    commit = 1'b1;
    blank = 1'b1;
    step();
    step();
    ph = 0;
    rst = 1'b0;
    blank = 1'b0;
    drive_idle();
    checks++;
    if (an !== 4'hF) begin
      failures++;
      $display("FAIL reset_an got=%h exp=F", an);
    end
    checks++;
    if (seg !== 8'hFF) begin
      failures++;
      $display("FAIL reset_seg got=%h exp=FF", seg);
    end
    checks++;
    if (commit_ack !== 1'b0) begin
      failures++;
      $display("FAIL reset_ack got=%b exp=0", commit_ack);
    end
    checks++;
    if (frame_tick !== 1'b0) begin
      failures++;
      $display("FAIL reset_tick got=%b exp=0", frame_tick);
    end
  endtask

  task automatic test_idle();
    ack_a = -1;
    ack_b = -1;
    while (ph < 32) begin
      drive_idle();
      adv();
      checks++;
      if (an !== exp_an(ph)) begin
        failures++;
        $display("FAIL idle_an ph=%0d got=%h exp=%h", ph, an, exp_an(ph));
      end
      checks++;
      if (seg !== exp_seg(ph)) begin
        failures++;
        $display("FAIL idle_seg ph=%0d got=%h exp=%h", ph, seg, exp_seg(ph));
      end
      checks++;
      if (frame_tick !== exp_tick(ph)) begin
        failures++;
        $display("FAIL idle_tick ph=%0d got=%b exp=%b", ph, frame_tick, exp_tick(ph));
      end
      checks++;
      if (commit_ack !== exp_ack(ph)) begin
        failures++;
        $display("FAIL idle_ack ph=%0d got=%b exp=%b", ph, commit_ack, exp_ack(ph));
      end
    end
  endtask

  task automatic test_commit();
    ack_a = 48;
    while (ph < 64) begin
      drive_idle();
      if (ph == 32) drive_wr(2'd0, 8'h03);
      if (ph == 33) drive_wr(2'd1, 8'h9F);
      if (ph == 35) commit = 1'b1;
      adv();
      checks++;
      if (an !== exp_an(ph)) begin
        failures++;
        $display("FAIL commit_an ph=%0d got=%h exp=%h", ph, an, exp_an(ph));
      end
      checks++;
      if (seg !== exp_seg(ph)) begin
        failures++;
        $display("FAIL commit_seg ph=%0d got=%h exp=%h", ph, seg, exp_seg(ph));
      end
      checks++;
      if (frame_tick !== exp_tick(ph)) begin
        failures++;
        $display("FAIL commit_tick ph=%0d got=%b exp=%b", ph, frame_tick, exp_tick(ph));
      end
      checks++;
      if (commit_ack !== exp_ack(ph)) begin
        failures++;
        $display("FAIL commit_ack ph=%0d got=%b exp=%b", ph, commit_ack, exp_ack(ph));
      end
    end
  endtask

  task automatic test_hold();
    ack_a = 112;
    while (ph < 128) begin
      drive_idle();
      if (ph == 64) drive_wr(2'd2, 8'h25);
      if (ph == 100) commit = 1'b1;
      adv();
      checks++;
      if (an !== exp_an(ph)) begin
        failures++;
        $display("FAIL hold_an ph=%0d got=%h exp=%h", ph, an, exp_an(ph));
      end
      checks++;
      if (seg !== exp_seg(ph)) begin
        failures++;
        $display("FAIL hold_seg ph=%0d got=%h exp=%h", ph, seg, exp_seg(ph));
      end
      checks++;
      if (frame_tick !== exp_tick(ph)) begin
        failures++;
        $display("FAIL hold_tick ph=%0d got=%b exp=%b", ph, frame_tick, exp_tick(ph));
      end
      checks++;
      if (commit_ack !== exp_ack(ph)) begin
        failures++;
        $display("FAIL hold_ack ph=%0d got=%b exp=%b", ph, commit_ack, exp_ack(ph));
      end
    end
  endtask

  task automatic test_back_to_back();
    ack_a = 144;
    ack_b = 176;
    while (ph < 192) begin
      drive_idle();
      if (ph == 143) begin
        commit = 1'b1;
        drive_wr(2'd0, 8'h01);
      end
      if (ph == 165) commit = 1'b1;
      adv();
      checks++;
      if (an !== exp_an(ph)) begin
        failures++;
        $display("FAIL b2b_an ph=%0d got=%h exp=%h", ph, an, exp_an(ph));
      end
      checks++;
      if (seg !== exp_seg(ph)) begin
        failures++;
        $display("FAIL b2b_seg ph=%0d got=%h exp=%h", ph, seg, exp_seg(ph));
      end
      checks++;
      if (frame_tick !== exp_tick(ph)) begin
        failures++;
        $display("FAIL b2b_tick ph=%0d got=%b exp=%b", ph, frame_tick, exp_tick(ph));
      end
      checks++;
      if (commit_ack !== exp_ack(ph)) begin
        failures++;
        $display("FAIL b2b_ack ph=%0d got=%b exp=%b", ph, commit_ack, exp_ack(ph));
      end
    end
  endtask

  task automatic test_blank();
    ack_a = 208;
    ack_b = -1;
    bl_lo = 193;
    bl_hi = 212;
    while (ph < 240) begin
      drive_idle();
      blank = (ph >= 192 && ph <= 211);
      if (ph == 193) drive_wr(2'd3, 8'h99);
      if (ph == 194) commit = 1'b1;
      adv();
      checks++;
      if (an !== exp_an(ph)) begin
        failures++;
        $display("FAIL blank_an ph=%0d got=%h exp=%h", ph, an, exp_an(ph));
      end
      checks++;
      if (seg !== exp_seg(ph)) begin
        failures++;
        $display("FAIL blank_seg ph=%0d got=%h exp=%h", ph, seg, exp_seg(ph));
      end
      checks++;
      if (frame_tick !== exp_tick(ph)) begin
        failures++;
        $display("FAIL blank_tick ph=%0d got=%b exp=%b", ph, frame_tick, exp_tick(ph));
      end
      checks++;
      if (commit_ack !== exp_ack(ph)) begin
        failures++;
        $display("FAIL blank_ack ph=%0d got=%b exp=%b", ph, commit_ack, exp_ack(ph));
      end
    end
    blank = 1'b0;
    bl_lo = -1;
    bl_hi = -2;
  endtask

  task automatic test_reset_mid();
    ack_a = -1;
    while (ph < 250) begin
      drive_idle();
      if (ph == 248) commit = 1'b1;
      adv();
    end
    rst = 1'b1;
    drive_wr(2'd0, 8'h55);
    commit = 1'b1;
    step();
    ph = 0;
    rst = 1'b0;
    drive_idle();
    for (int i = 0; i < 4; i++) begin
      sh[i] = 8'hFF;
      ed[i] = 8'hFF;
    end
    checks++;
    if (an !== 4'hF || seg !== 8'hFF) begin
      failures++;
      $display("FAIL midrst_out got=%h/%h exp=F/FF", an, seg);
    end
    ack_a = 32;
    while (ph < 48) begin
      drive_idle();
      if (ph == 17) commit = 1'b1;
      adv();
      checks++;
      if (an !== exp_an(ph)) begin
        failures++;
        $display("FAIL midrst_an ph=%0d got=%h exp=%h", ph, an, exp_an(ph));
      end
      checks++;
      if (seg !== exp_seg(ph)) begin
        failures++;
        $display("FAIL midrst_seg ph=%0d got=%h exp=%h", ph, seg, exp_seg(ph));
      end
      checks++;
      if (frame_tick !== exp_tick(ph)) begin
        failures++;
        $display("FAIL midrst_tick ph=%0d got=%b exp=%b", ph, frame_tick, exp_tick(ph));
      end
      checks++;
      if (commit_ack !== exp_ack(ph)) begin
        failures++;
        $display("FAIL midrst_ack ph=%0d got=%b exp=%b", ph, commit_ack, exp_ack(ph));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      sh[i] = 8'hFF;
      ed[i] = 8'hFF;
    end
    test_reset();
    test_idle();
    test_commit();
    test_hold();
    test_back_to_back();
    test_blank();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog ph=%0d got=timeout exp=done", ph);
    $fatal(1, "watchdog");
  end

endmodule
